// File: rtl/emmc_blk_pattern_pkg.sv
// Shared types and LFSR helpers for the eMMC block pattern generator/checker.
package emmc_pat_p;

  typedef logic [2:0] pat_state_t;

  localparam pat_state_t ST_IDLE    = 3'd0;
  localparam pat_state_t ST_W_START = 3'd1;
  localparam pat_state_t ST_W_XFER  = 3'd2;
  localparam pat_state_t ST_R_START = 3'd3;
  localparam pat_state_t ST_R_XFER  = 3'd4;
  localparam pat_state_t ST_DONE    = 3'd5;

  // x^8+x^6+x^5+x^4+1, shifting toward the MSB
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/emmc_blk_pattern_if.sv
// Byte-side handshake between the pattern block (master) and emmc_sm (slave).
interface emmc_blk_pattern_if;
  logic       start;
  logic       we;
  logic [7:0] wdat;
  logic       ready;
  logic       dvalid;
  logic [7:0] rdat;

  modport master (output start, we, wdat, input ready, dvalid, rdat);
  modport slave  (input start, we, wdat, output ready, dvalid, rdat);
endinterface

// File: rtl/emmc_blk_pattern_lfsr.sv
// Pattern LFSR shared by the write and read phases; load takes priority over step.
module pattern_lfsr
  import emmc_pat_p::*;
#(
  parameter logic [7:0] SEED = 8'h01
) (
  input  logic       clk_core,
  input  logic       rst_tk,
  input  logic       load_i,
  input  logic       step_i,
  input  logic [7:0] seed_i,
  output logic [7:0] byte_o
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      // an all-zero LFSR would lock up
      lfsr_d = (seed_i == 8'h00) ? 8'h01 : seed_i;
    end else if (step_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk_core or posedge rst_tk) begin
    if (rst_tk) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign byte_o = lfsr_q;

endmodule

// File: rtl/emmc_blk_pattern.sv
// eMMC test traffic: alternating single-block write/read passes through emmc_sm,
// LFSR payload on writes, read-back compare and status counters.
module emmc_blk_pattern
  import emmc_pat_p::*;
#(
  parameter int         BLK_BYTES = 512,
  parameter logic [7:0] SEED      = 8'h01,
  parameter int         MAX_PASS  = 0
) (
  input  logic               clk_core,
  input  logic               rst_tk,
  input  logic               enable_i,
  emmc_blk_pattern_if.master bus,
  output logic [15:0]        pass_cnt_o,
  output logic [15:0]        err_cnt_o,
  output logic               len_err_o,
  output logic [15:0]        fail_idx_o,
  output logic               done_o
);

  localparam int               CNT_W   = $clog2(BLK_BYTES) + 1;
  localparam logic [CNT_W-1:0] BLK_CNT = CNT_W'(BLK_BYTES);
  localparam logic [15:0]      MAX_CNT = 16'(MAX_PASS);

  pat_state_t       state_q, state_d;
  logic             start_q, start_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [15:0]      pass_q, pass_d;
  logic [15:0]      err_q, err_d;
  logic [15:0]      fail_idx_q, fail_idx_d;
  logic             fail_seen_q, fail_seen_d;
  logic             len_err_q, len_err_d;
  logic             done_q, done_d;

  logic             lfsr_load, lfsr_step;
  logic [7:0]       lfsr_byte;
  logic             xfer, take_byte;
  logic [CNT_W-1:0] byte_cnt_inc, cnt_now;

  pattern_lfsr #(.SEED(SEED)) u_lfsr (
    .clk_core (clk_core),
    .rst_tk   (rst_tk),
    .load_i   (lfsr_load),
    .step_i   (lfsr_step),
    .seed_i   (SEED ^ pass_q[7:0]),
    .byte_o   (lfsr_byte)
  );

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    we_d        = we_q;
    byte_cnt_d  = byte_cnt_q;
    pass_d      = pass_q;
    err_d       = err_q;
    fail_idx_d  = fail_idx_q;
    fail_seen_d = fail_seen_q;
    len_err_d   = len_err_q;
    done_d      = done_q;
    lfsr_load   = 1'b0;
    lfsr_step   = 1'b0;

    xfer         = (state_q == ST_W_XFER) || (state_q == ST_R_XFER);
    take_byte    = xfer && bus.dvalid;
    byte_cnt_inc = (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_q + 1'b1;
    // count including a byte that arrives with the exit edge
    cnt_now      = take_byte ? byte_cnt_inc : byte_cnt_q;

    if (take_byte) begin
      lfsr_step  = 1'b1;
      byte_cnt_d = byte_cnt_inc;
    end

    if (state_q == ST_R_XFER && bus.dvalid && bus.rdat != lfsr_byte) begin
      if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
      if (!fail_seen_q) begin
        fail_seen_d = 1'b1;
        fail_idx_d  = 16'(byte_cnt_q);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (enable_i && bus.ready && !done_q) begin
          state_d    = ST_W_START;
          start_d    = 1'b1;
          we_d       = 1'b1;
          byte_cnt_d = '0;
          lfsr_load  = 1'b1;
        end
      end
      ST_W_START: begin
        if (!bus.ready) begin
          state_d = ST_W_XFER;
          start_d = 1'b0;
        end
      end
      ST_W_XFER: begin
        if (bus.ready) begin
          if (cnt_now != BLK_CNT) len_err_d = 1'b1;
          state_d    = ST_R_START;
          start_d    = 1'b1;
          we_d       = 1'b0;
          byte_cnt_d = '0;
          lfsr_load  = 1'b1;
        end
      end
      ST_R_START: begin
        if (!bus.ready) begin
          state_d = ST_R_XFER;
          start_d = 1'b0;
        end
      end
      ST_R_XFER: begin
        if (bus.ready) begin
          if (cnt_now != BLK_CNT) len_err_d = 1'b1;
          pass_d = pass_q + 16'd1;
          if (MAX_PASS != 0 && pass_d == MAX_CNT) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_core or posedge rst_tk) begin
    if (rst_tk) begin
      state_q     <= ST_IDLE;
      start_q     <= 1'b0;
      we_q        <= 1'b1;
      byte_cnt_q  <= '0;
      pass_q      <= '0;
      err_q       <= '0;
      fail_idx_q  <= '0;
      fail_seen_q <= 1'b0;
      len_err_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      we_q        <= we_d;
      byte_cnt_q  <= byte_cnt_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      fail_idx_q  <= fail_idx_d;
      fail_seen_q <= fail_seen_d;
      len_err_q   <= len_err_d;
      done_q      <= done_d;
    end
  end

  assign bus.start  = start_q;
  assign bus.we     = we_q;
  assign bus.wdat   = lfsr_byte;
  assign pass_cnt_o = pass_q;
  assign err_cnt_o  = err_q;
  assign len_err_o  = len_err_q;
  assign fail_idx_o = fail_idx_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_emmc_blk_pattern.sv
// Bench for emmc_blk_pattern: behavioural emmc_sm byte-side model, golden LFSR,
// write-byte scoreboard, table of single-pass scenarios and hand-written sequences.
`timescale 1ns/1ps
module tb_emmc_blk_pattern;

  logic        clk_core = 1'b0;
  logic        rst_tk   = 1'b1;
  logic        enable   = 1'b0;
  logic [15:0] pass_cnt, err_cnt, fail_idx;
  logic        len_err, done;

  emmc_blk_pattern_if bus();

  emmc_blk_pattern #(.BLK_BYTES(512), .SEED(8'h01), .MAX_PASS(2)) dut (
    .clk_core   (clk_core),
    .rst_tk     (rst_tk),
    .enable_i   (enable),
    .bus        (bus),
    .pass_cnt_o (pass_cnt),
    .err_cnt_o  (err_cnt),
    .len_err_o  (len_err),
    .fail_idx_o (fail_idx),
    .done_o     (done)
  );

  always #5 clk_core = ~clk_core;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gold_next(input logic [7:0] s);
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], fb};
  endfunction

  function automatic logic [7:0] gold_seed(input int pass);
    logic [7:0] s;
    s = 8'h01 ^ pass[7:0];
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

  // emmc_sm byte-side model controls
  int         wr_len = 512, rd_len = 512, corrupt_a = -1, corrupt_b = -1;
  bit         same_cycle = 0, corrupt_all = 0, kill = 0, busy = 0;
  int         phase = 0;      // 0 idle, 1 write transfer, 2 read transfer
  int         exp_pass = 0;
  logic [7:0] mem [0:1023];
  logic [7:0] exp_q [$];

  logic [7:0] g_lfsr, rb;
  int         m_len;
  bit         m_wr;

  initial begin
    bus.ready  = 1'b1;
    bus.dvalid = 1'b0;
    bus.rdat   = 8'h00;
    forever begin
      @(negedge clk_core);
      if (!kill && !rst_tk && bus.start && bus.ready) begin
        busy   = 1;
        m_wr   = bus.we;
        g_lfsr = gold_seed(exp_pass);
        m_len  = m_wr ? wr_len : rd_len;
        @(posedge clk_core); #1;
        bus.ready = 1'b0;
        phase = m_wr ? 1 : 2;
        @(posedge clk_core); #1;
        for (int i = 0; i < m_len && !kill; i++) begin
          bus.dvalid = 1'b1;
          if (m_wr) begin
            exp_q.push_back(g_lfsr);
            if (i < 1024) mem[i] = bus.wdat;
          end else begin
            rb = (i < 1024) ? mem[i] : g_lfsr;
            if (corrupt_all || i == corrupt_a || i == corrupt_b) rb = rb ^ 8'h01;
            bus.rdat = rb;
          end
          g_lfsr = gold_next(g_lfsr);
          if (same_cycle && i == m_len - 1) bus.ready = 1'b1;
          @(posedge clk_core); #1;
          bus.dvalid = 1'b0;
        end
        bus.ready = 1'b1;
        if (!m_wr && !kill) exp_pass++;
        phase = 0;
        busy  = 0;
      end
    end
  end

  // write-data scoreboard: expected byte pushed when the model strobes, popped here
  always @(negedge clk_core) begin
    if (phase == 1 && bus.dvalid && !kill && !rst_tk) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        if (n_err <= 40) $display("FAIL wr_byte: got %0h expected <none queued>", bus.wdat);
      end else begin
        chk("wr_byte", bus.wdat, exp_q.pop_front());
      end
    end
  end

  task automatic set_model(input int wl, input int rl, input int ca, input int cb,
                           input bit sc, input bit ca_all);
    wr_len = wl; rd_len = rl; corrupt_a = ca; corrupt_b = cb;
    same_cycle = sc; corrupt_all = ca_all;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    rst_tk = 1'b1;
    kill   = 1;
    for (int i = 0; i < 100 && busy; i++) @(posedge clk_core);
    #1;
    exp_q.delete();
    exp_pass   = 0;
    bus.ready  = 1'b1;
    bus.dvalid = 1'b0;
    kill       = 0;
    repeat (2) @(posedge clk_core);
    #1 rst_tk = 1'b0;
  endtask

  task automatic wait_pass(input logic [15:0] target, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_core);
      if (pass_cnt == target) break;
    end
    chk(name, pass_cnt, target);
  endtask

  task automatic wait_phase(input int ph, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_core);
      if (phase == ph) break;
    end
    chk(name, phase, ph);
  endtask

  task automatic pulse_enable();
    @(negedge clk_core) enable = 1'b1;
    @(negedge clk_core) enable = 1'b0;
  endtask

  typedef struct {
    int          wr_len;
    int          rd_len;
    int          ca;
    int          cb;
    bit          same;
    bit          all;
    logic [15:0] e_err;
    logic [15:0] e_fidx;
    bit          e_len;
    int          budget;
  } vec_t;

  vec_t vecs [7];
  bit   saw_start;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{512, 512,   -1,  -1, 0, 0, 16'd0,      16'd0,   0, 3000};
    vecs[1] = '{512, 512,    5, 300, 0, 0, 16'd2,      16'd5,   0, 3000};
    vecs[2] = '{511, 512,   -1,  -1, 0, 0, 16'd1,      16'd511, 1, 3000};
    vecs[3] = '{512, 512,   -1,  -1, 1, 0, 16'd0,      16'd0,   0, 3000};
    vecs[4] = '{512, 100,   -1,  -1, 0, 0, 16'd0,      16'd0,   1, 3000};
    vecs[5] = '{512, 513,   -1,  -1, 0, 0, 16'd1,      16'd512, 1, 3000};
    vecs[6] = '{512, 70000, -1,  -1, 0, 1, 16'hFFFF,   16'd0,   1, 72000};

    // T1: reset in the middle of a write transfer
    set_model(512, 512, -1, -1, 0, 0);
    do_reset();
    pulse_enable();
    wait_phase(1, 50, "t1_reach_wxfer");
    repeat (20) @(posedge clk_core);
    #1;
    rst_tk = 1'b1;
    kill   = 1;
    @(negedge clk_core);
    chk("t1_start", bus.start, 1'b0);
    chk("t1_we", bus.we, 1'b1);
    chk("t1_dat", bus.wdat, 8'h01);
    chk("t1_pass", pass_cnt, 16'd0);
    chk("t1_err", err_cnt, 16'd0);
    chk("t1_len", len_err, 1'b0);
    chk("t1_fidx", fail_idx, 16'd0);
    chk("t1_done", done, 1'b0);

    // table of single-pass scenarios (covers T3, T4, T5 boundary and saturation)
    foreach (vecs[k]) begin
      set_model(vecs[k].wr_len, vecs[k].rd_len, vecs[k].ca, vecs[k].cb,
                vecs[k].same, vecs[k].all);
      do_reset();
      pulse_enable();
      wait_pass(16'd1, vecs[k].budget, $sformatf("v%0d_pass", k));
      repeat (3) @(negedge clk_core);
      chk($sformatf("v%0d_err", k), err_cnt, vecs[k].e_err);
      chk($sformatf("v%0d_fidx", k), fail_idx, vecs[k].e_fidx);
      chk($sformatf("v%0d_len", k), len_err, vecs[k].e_len);
      chk($sformatf("v%0d_done", k), done, 1'b0);
      chk($sformatf("v%0d_start", k), bus.start, 1'b0);
    end

    // T2: two clean passes, then DONE holds; pass 2 reload exercises the zero-seed fix
    set_model(512, 512, -1, -1, 0, 0);
    do_reset();
    @(negedge clk_core) enable = 1'b1;
    wait_pass(16'd1, 3000, "t2_pass1");
    wait_pass(16'd2, 3000, "t2_pass2");
    repeat (3) @(negedge clk_core);
    chk("t2_done", done, 1'b1);
    chk("t2_err", err_cnt, 16'd0);
    chk("t2_len", len_err, 1'b0);
    chk("t2_byte0", mem[0], 8'h01);
    chk("t2_byte1", mem[1], gold_next(8'h01));
    chk("t2_byte2", mem[2], gold_next(gold_next(8'h01)));
    saw_start = 0;
    repeat (30) begin
      @(negedge clk_core);
      if (bus.start) saw_start = 1;
    end
    chk("t2_no_restart", saw_start, 1'b0);
    chk("t2_pass_hold", pass_cnt, 16'd2);
    enable = 1'b0;

    // T6: drop enable during the read; pass completes and the block parks
    set_model(512, 512, -1, -1, 0, 0);
    do_reset();
    @(negedge clk_core) enable = 1'b1;
    wait_phase(2, 1000, "t6_reach_rxfer");
    repeat (50) @(negedge clk_core);
    enable = 1'b0;
    wait_pass(16'd1, 1000, "t6_pass");
    saw_start = 0;
    repeat (40) begin
      @(negedge clk_core);
      if (bus.start) saw_start = 1;
    end
    chk("t6_no_start", saw_start, 1'b0);
    chk("t6_pass_hold", pass_cnt, 16'd1);
    chk("t6_done", done, 1'b0);
    chk("t6_err", err_cnt, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
